// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
// button_debounce_if
// Raw button pin plus the debounced event outputs of button_debounce.
// Revision: 1.0
// ============================================================================
interface button_debounce_if;
  logic       btn_i;
  logic       btn_o;
  logic       press_o;
  logic       release_o;
  logic       long_o;
  logic [7:0] press_cnt_o;

  modport master (
    input  btn_i,
    output btn_o, press_o, release_o, long_o, press_cnt_o
  );

  modport slave (
    output btn_i,
    input  btn_o, press_o, release_o, long_o, press_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce
// Synchronise and debounce one push-button pin into level, pulse and count
// events. Define BTN_LONG_PRESS_EN to build the long-press detector.
// Revision: 1.0
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int LONG_CYCLES     = 12_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  button_debounce_if.master   bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_debounce: LONG_CYCLES must be >= 2");
    end
  endgenerate

  logic          w_p;
  logic          s1_q, s2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [7:0]    press_cnt_q, press_cnt_d;
  logic          w_press_acc, w_release_acc;

  assign w_p = ACTIVE_LOW ? ~bus.btn_i : bus.btn_i;

  // Synchroniser stores the polarity-corrected level, so reset = not pressed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= w_p;
      s2_q <= s1_q;
    end
  end

  assign w_press_acc   = (state_q == ST_PRESS_WAIT)   &&  s2_q && (cnt_q == DB_LAST);
  assign w_release_acc = (state_q == ST_RELEASE_WAIT) && !s2_q && (cnt_q == DB_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      btn_q       <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_q       <= btn_d;
      press_q     <= press_d;
      release_q   <= release_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s2_q)            state_d = ST_IDLE;
        else if (w_press_acc) state_d = ST_PRESSED;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      ST_PRESSED: begin
        if (!s2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (s2_q)               state_d = ST_PRESSED;
        else if (w_release_acc) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + CW'(1);
      end
    endcase
  end

  always_comb begin
    btn_d       = btn_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    press_cnt_d = press_cnt_q;
    if (w_press_acc) begin
      btn_d       = 1'b1;
      press_d     = 1'b1;
      press_cnt_d = press_cnt_q + 8'd1;
    end else if (w_release_acc) begin
      btn_d     = 1'b0;
      release_d = 1'b1;
    end
  end

  assign bus.btn_o       = btn_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.press_cnt_o = press_cnt_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_q, long_d;
  logic          long_done_q, long_done_d;
  logic          long_pulse_q, long_pulse_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      long_q       <= '0;
      long_done_q  <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_done_q  <= long_done_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  // Fires once when the saturated count is observed; done flag blocks re-fire.
  always_comb begin
    long_d       = long_q;
    long_done_d  = long_done_q;
    long_pulse_d = 1'b0;
    if (w_press_acc) begin
      long_d      = '0;
      long_done_d = 1'b0;
    end else if ((state_q == ST_PRESSED) && s2_q) begin
      if (long_q != LONG_LAST) begin
        long_d = long_q + LW'(1);
      end else if (!long_done_q) begin
        long_pulse_d = 1'b1;
        long_done_d  = 1'b1;
      end
    end
  end

  assign bus.long_o = long_pulse_q;
`else
  assign bus.long_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart of the LED blink output path. Conditions one raw push-button pin into clean, registered, single-clock-domain events.
- Pipeline: 2-flop synchroniser, then a debounce FSM, then outputs.
- Outputs: debounced level, one-cycle press/release pulses, optional long-press pulse, and a wrapping press counter for downstream LED/UI logic.

Parameters:
- DEBOUNCE_CYCLES, 120_000, cycles the synchronised input must stay stable to accept a transition (10 ms at 12 MHz). Must be >= 2; elaboration error otherwise.
- LONG_CYCLES, 12_000_000, cycles held in the PRESSED state before long_o fires (1 s at 12 MHz). Must be >= 2.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- btn_i  input  1  raw, asynchronous button pin
- btn_o  output  1  debounced pressed level, 1 = pressed
- press_o  output  1  one-cycle pulse on an accepted press
- release_o  output  1  one-cycle pulse on an accepted release
- long_o  output  1  one-cycle pulse when a held press reaches LONG_CYCLES
- press_cnt_o  output  8  count of accepted presses, wraps

Behaviour:
- Reset: one clock, clk_i. rst_i is asynchronous, active-high.
  - On rst_i: all flops clear immediately.
  - btn_o=0, press_o=0, release_o=0, long_o=0, press_cnt_o=0.
  - FSM returns to IDLE. Synchroniser flops hold logical "not pressed".
  - Reset mid-press emits no release_o.
- Polarity: p = ACTIVE_LOW ? ~btn_i : btn_i. p passes through 2 flops, s1 then s2. sync = s2.
- Counters:
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES). Long counter width is $clog2(LONG_CYCLES).
  - Both are unsigned. They never wrap; the FSM clears them before overflow.
- FSM states are IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT:
  - IDLE: if sync=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - sync=0: go to IDLE (bounce rejected, no pulse).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED. Set btn_o<=1, press_o<=1, press_cnt_o<=press_cnt_o+1 (255 wraps to 0), long counter<=0.
    - Otherwise: cnt<=cnt+1.
  - PRESSED:
    - sync=0: go to RELEASE_WAIT and set cnt=0.
    - Otherwise: the long counter increments and saturates at LONG_CYCLES-1.
    - On the cycle it first reaches LONG_CYCLES-1, long_o<=1 for one cycle. long_o fires once per press.
  - RELEASE_WAIT:
    - sync=1: go back to PRESSED. btn_o stays 1, no pulses, long counter holds its value.
    - sync=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE. Set btn_o<=0, release_o<=1.
    - Otherwise: cnt<=cnt+1.
    - The long counter does not advance in this state.
- Latency:
  - Count edges with edge 1 = the first clk_i edge that samples p=1 stably.
  - press_o is high in the cycle following edge DEBOUNCE_CYCLES+3. btn_o rises in the same cycle.
  - Release is symmetric: release_o follows edge DEBOUNCE_CYCLES+3 after p first samples 0.
- Pulse rules:
  - press_o, release_o and long_o are registered, one cycle wide, and mutually exclusive.
  - press_o and release_o can never be adjacent; at least DEBOUNCE_CYCLES+1 cycles separate them.
- All outputs are registered. There is no combinational path from btn_i to any output.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined: the long-press counter and long_o behave as described above.
- Undefined: the long counter is not generated, long_o is tied to 0, and LONG_CYCLES is ignored. All other behaviour is unchanged.

Test Plan:
- Use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1 unless stated otherwise.
- Clean press: btn_i 1->0 held 30 cycles -> press_o=1 for exactly one cycle after edge 7, btn_o=1 from that cycle, press_cnt_o=1. Then btn_i->1 -> release_o one cycle after edge 7, btn_o=0.
- Bounce reject: btn_i low 3 cycles, high 2, low 2, then high -> no press_o, btn_o stays 0, press_cnt_o stays 0.
- Release bounce: while pressed, btn_i high 2 cycles then low again -> no release_o, btn_o stays 1 throughout.
- Long press (BTN_LONG_PRESS_EN defined): hold low 40 cycles -> long_o exactly once, 20 cycles after press_o, then no further pulses. Rebuild without the macro -> long_o constant 0.
- Wrap and reset: 256 clean presses -> press_cnt_o reads 0.
- Reset mid-press: assert rst_i asynchronously mid-press -> all outputs 0 immediately. Release btn_i afterwards -> no release_o.
- Polarity: ACTIVE_LOW=0, btn_i 0->1 held -> press_o after edge 7.
